mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - instruction/data/memory port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              a_i_isyn;
    logic [AWIDTH-1:0] a_i_iaddr;
    logic              a_o_iack;
    logic [DWIDTH-1:0] a_o_idata;

    logic              a_i_dsyn;
    logic              a_i_dwe;
    logic [AWIDTH-1:0] a_i_daddr;
    logic [DWIDTH-1:0] a_i_dwdata;
    logic [3:0]        a_i_dwsel;
    logic              a_o_dack;
    logic [DWIDTH-1:0] a_o_ddata;

    logic              a_i_flush;

    logic              a_o_msyn;
    logic              a_o_mwe;
    logic [AWIDTH-1:0] a_o_maddr;
    logic [DWIDTH-1:0] a_o_mwdata;
    logic [3:0]        a_o_mwsel;
    logic              a_i_mack;
    logic [DWIDTH-1:0] a_i_mdata;

    logic              a_o_busy;
    logic              a_o_gnt_d;

    modport slave (
        input  a_i_isyn, a_i_iaddr, a_i_dsyn, a_i_dwe, a_i_daddr, a_i_dwdata,
               a_i_dwsel, a_i_flush, a_i_mack, a_i_mdata,
        output a_o_iack, a_o_idata, a_o_dack, a_o_ddata, a_o_msyn, a_o_mwe,
               a_o_maddr, a_o_mwdata, a_o_mwsel, a_o_busy, a_o_gnt_d
    );

    modport master (
        output a_i_isyn, a_i_iaddr, a_i_dsyn, a_i_dwe, a_i_daddr, a_i_dwdata,
               a_i_dwsel, a_i_flush, a_i_mack, a_i_mdata,
        input  a_o_iack, a_o_idata, a_o_dack, a_o_ddata, a_o_msyn, a_o_mwe,
               a_o_maddr, a_o_mwdata, a_o_mwsel, a_o_busy, a_o_gnt_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - data-priority instruction/data memory arbiter with starvation guard
module mem_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          a_clk,
    input  logic          a_rst,
    mem_arbiter_if.slave  bus
);
    localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DROP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     starve_q, starve_d;
    logic              msyn_q, msyn_d;
    logic              mwe_q, mwe_d;
    logic [AWIDTH-1:0] maddr_q, maddr_d;
    logic [DWIDTH-1:0] mwdata_q, mwdata_d;
    logic [3:0]        mwsel_q, mwsel_d;
    logic              iack_q, iack_d;
    logic [DWIDTH-1:0] idata_q, idata_d;
    logic              dack_q, dack_d;
    logic [DWIDTH-1:0] ddata_q, ddata_d;
    logic              busy_q, busy_d;
    logic              gnt_d_q, gnt_d_d;
    logic              starve_force;

    assign starve_force = (starve_q == STARVE_LIM) && bus.a_i_isyn && !bus.a_i_flush;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        msyn_d   = msyn_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwsel_d  = mwsel_q;
        iack_d   = 1'b0;
        idata_d  = idata_q;
        dack_d   = 1'b0;
        ddata_d  = ddata_q;
        gnt_d_d  = gnt_d_q;
        case (state_q)
            IDLE: begin
                if (bus.a_i_dsyn && !starve_force) begin
                    state_d  = BUSY_D;
                    msyn_d   = 1'b1;
                    mwe_d    = bus.a_i_dwe;
                    maddr_d  = bus.a_i_daddr;
                    mwdata_d = bus.a_i_dwdata;
                    mwsel_d  = bus.a_i_dwsel;
                    gnt_d_d  = 1'b1;
                    // Only a waiting instruction fetch counts toward starvation
                    if (!bus.a_i_isyn)
                        starve_d = '0;
                    else if (starve_q != STARVE_LIM)
                        starve_d = starve_q + CW'(1);
                end else if (bus.a_i_isyn && !bus.a_i_flush) begin
                    state_d  = BUSY_I;
                    msyn_d   = 1'b1;
                    mwe_d    = 1'b0;
                    maddr_d  = bus.a_i_iaddr;
                    mwdata_d = '0;
                    mwsel_d  = 4'h0;
                    gnt_d_d  = 1'b0;
                    starve_d = '0;
                end
            end
            BUSY_D: begin
                if (bus.a_i_mack) begin
                    state_d = IDLE;
                    msyn_d  = 1'b0;
                    dack_d  = 1'b1;
                    ddata_d = bus.a_i_mdata;
                end
            end
            BUSY_I: begin
                if (bus.a_i_mack) begin
                    state_d = IDLE;
                    msyn_d  = 1'b0;
                    if (!bus.a_i_flush) begin
                        iack_d  = 1'b1;
                        idata_d = bus.a_i_mdata;
                    end
                end else if (bus.a_i_flush) begin
                    // Memory must still finish the access; its result is dropped
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.a_i_mack) begin
                    state_d = IDLE;
                    msyn_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            msyn_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwsel_q  <= 4'h0;
            iack_q   <= 1'b0;
            idata_q  <= '0;
            dack_q   <= 1'b0;
            ddata_q  <= '0;
            busy_q   <= 1'b0;
            gnt_d_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            msyn_q   <= msyn_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwsel_q  <= mwsel_d;
            iack_q   <= iack_d;
            idata_q  <= idata_d;
            dack_q   <= dack_d;
            ddata_q  <= ddata_d;
            busy_q   <= busy_d;
            gnt_d_q  <= gnt_d_d;
        end
    end

    assign bus.a_o_msyn   = msyn_q;
    assign bus.a_o_mwe    = mwe_q;
    assign bus.a_o_maddr  = maddr_q;
    assign bus.a_o_mwdata = mwdata_q;
    assign bus.a_o_mwsel  = mwsel_q;
    assign bus.a_o_iack   = iack_q;
    assign bus.a_o_idata  = idata_q;
    assign bus.a_o_dack   = dack_q;
    assign bus.a_o_ddata  = ddata_q;
    assign bus.a_o_busy   = busy_q;
    assign bus.a_o_gnt_d  = gnt_d_q;
endmodule
